// File: rtl/drac_l15_req_arbiter_pkg.sv
// drac_l15_req_arbiter_pkg: shared sizes, port ids and types for the L1.5 request arbiter
package drac_l15_req_arbiter_pkg;
    localparam int NUM_PORTS       = 5;
    localparam int PAYLOAD_W       = 128;
    localparam int MAX_OUTSTANDING = 4;
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1);
    localparam int PORTID_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    typedef logic [PORTID_W-1:0] l15_arb_portid_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic {IDLE, ISSUE} arb_state_t;
    localparam l15_arb_portid_t ICACHE = 0;
    localparam l15_arb_portid_t DMISS  = 1;
    localparam l15_arb_portid_t WBUF   = 2;
    localparam l15_arb_portid_t UCRD   = 3;
    localparam l15_arb_portid_t UCWR   = 4;
endpackage

// File: rtl/drac_l15_req_arbiter_if.sv
// drac_l15_req_arbiter_if: core request ports, L1.5 request/return channel and debug status
interface drac_l15_req_arbiter_if;
    import drac_l15_req_arbiter_pkg::*;
    logic [NUM_PORTS-1:0]           req_valid;
    logic [NUM_PORTS-1:0]           req_ready;
    logic [NUM_PORTS*PAYLOAD_W-1:0] req_payload;
    logic                           l15_val;
    logic [PAYLOAD_W-1:0]           l15_payload;
    l15_arb_portid_t                l15_portid;
    logic                           l15_header_ack;
    logic                           rtrn_valid;
    l15_arb_portid_t                rtrn_portid;
    logic [NUM_PORTS*CNT_W-1:0]     outst_cnt;
    logic                           err;
    modport master (
        input  req_valid, req_payload, l15_header_ack, rtrn_valid, rtrn_portid,
        output req_ready, l15_val, l15_payload, l15_portid, outst_cnt, err
    );
    modport slave (
        output req_valid, req_payload, l15_header_ack, rtrn_valid, rtrn_portid,
        input  req_ready, l15_val, l15_payload, l15_portid, outst_cnt, err
    );
endinterface

// File: rtl/drac_l15_req_arbiter_rr_arbiter.sv
// drac_rr_arbiter: combinational round-robin pick, first request at or after ptr
module drac_rr_arbiter
    import drac_l15_req_arbiter_pkg::*;
#(
    parameter int N = NUM_PORTS
) (
    input  logic [N-1:0]    req,
    input  l15_arb_portid_t ptr,
    output logic [N-1:0]    grant,
    output l15_arb_portid_t idx,
    output logic            any
);
    logic [N-1:0]          rot;
    logic [PORTID_W-1:0]   off;
    logic [PORTID_W:0]     sum;
    assign any = |req;
    // rot[k] is req[(ptr+k) mod N], so the lowest set bit is the winner's offset
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) off = PORTID_W'(k);
        sum = {1'b0, ptr} + {1'b0, off};
        idx = (sum >= (PORTID_W+1)'(N)) ? PORTID_W'(sum - (PORTID_W+1)'(N)) : sum[PORTID_W-1:0];
        grant = any ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/drac_l15_req_arbiter.sv
// drac_l15_req_arbiter: round-robin arbiter of core request streams onto the single L1.5 slot
// with per-port outstanding credits returned by the L1.5 completion path.
module drac_l15_req_arbiter
    import drac_l15_req_arbiter_pkg::*;
(
    input logic clk,
    input logic rst,
    drac_l15_req_arbiter_if.master bus
);
    arb_state_t           state, state_nxt;
    l15_arb_portid_t      ptr, win, portid;
    logic [PAYLOAD_W-1:0] payload;
    logic [NUM_PORTS-1:0] elig, grant, inc, dec, zero;
    logic                 any, take, err;
    cnt_t                 cnt [NUM_PORTS];

    drac_rr_arbiter #(.N(NUM_PORTS)) u_rr (
        .req   (elig),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign elig[i] = bus.req_valid[i] & (cnt[i] < cnt_t'(MAX_OUTSTANDING));
        assign inc[i]  = take & grant[i];
        assign dec[i]  = bus.rtrn_valid & (bus.rtrn_portid == l15_arb_portid_t'(i));
        assign zero[i] = (cnt[i] == '0);
        assign bus.outst_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end

    always_comb begin
        take      = ~rst & ((state == IDLE) | bus.l15_header_ack) & any;
        state_nxt = take ? ISSUE : (bus.l15_header_ack ? IDLE : state);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            portid  <= '0;
            payload <= '0;
            err     <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
        end else begin
            state <= state_nxt;
            // a completion with no in-flight transaction to retire (zero count or bad id)
            err   <= err | (bus.rtrn_valid & ~|(dec & ~zero));
            if (take) begin
                payload <= bus.req_payload[win*PAYLOAD_W +: PAYLOAD_W];
                portid  <= win;
                ptr     <= (win == l15_arb_portid_t'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
            end
            for (int i = 0; i < NUM_PORTS; i++)
                if (inc[i] != dec[i] && !(dec[i] && zero[i]))
                    cnt[i] <= inc[i] ? cnt[i] + 1'b1 : cnt[i] - 1'b1;
        end
    end

    assign bus.req_ready   = take ? grant : '0;
    assign bus.l15_val     = (state == ISSUE);
    assign bus.l15_payload = payload;
    assign bus.l15_portid  = portid;
    assign bus.err         = err;
endmodule

// File: tb/tb_drac_l15_req_arbiter.sv
// tb_drac_l15_req_arbiter: scoreboard bench; expected L1.5 requests queued at accept time,
// compared when the L1.5 header is acked.
module tb_drac_l15_req_arbiter;
    import drac_l15_req_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    drac_l15_req_arbiter_if bus ();
    drac_l15_req_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        l15_arb_portid_t id;
        logic [127:0]    pl;
    } txn_t;

    txn_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pl(input int p, input int k);
        return {32'(p), 32'(k), 64'hC0DE_0000_0000_0000};
    endfunction

    function automatic logic [127:0] cnt_of(input int i);
        return 128'(bus.outst_cnt[i*CNT_W +: CNT_W]);
    endfunction

    task automatic set_pl(input int p, input logic [127:0] v);
        bus.req_payload[p*PAYLOAD_W +: PAYLOAD_W] = v;
    endtask

    task automatic expect_req(input int p, input logic [127:0] v);
        sbq.push_back('{id: l15_arb_portid_t'(p), pl: v});
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
        end else if (bus.l15_val && bus.l15_header_ack) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", 128'(1), 128'(0));
            end else begin
                txn_t e;
                e = sbq.pop_front();
                chk("sb_portid", 128'(bus.l15_portid), 128'(e.id));
                chk("sb_payload", bus.l15_payload, e.pl);
            end
        end
    end

    initial begin
        bus.req_valid      = '0;
        bus.req_payload    = '0;
        bus.l15_header_ack = 1'b0;
        bus.rtrn_valid     = 1'b0;
        bus.rtrn_portid    = '0;
        bus.req_valid      = '1;
        @(negedge clk);
        chk("rst_ready", 128'(bus.req_ready), 128'(0));
        chk("rst_val", 128'(bus.l15_val), 128'(0));
        chk("rst_err", 128'(bus.err), 128'(0));
        chk("rst_cnt", 128'(bus.outst_cnt), 128'(0));
        chk("rst_portid", 128'(bus.l15_portid), 128'(0));
        next();
        rst = 1'b0;
        bus.req_valid = '0;

        // single request, ack on the third issue cycle
        set_pl(2, 128'hABCD);
        bus.req_valid = 5'b00100;
        expect_req(2, 128'hABCD);
        @(negedge clk);
        chk("single_ready", 128'(bus.req_ready), 128'(5'b00100));
        next();
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.l15_header_ack = 1'b1;
            @(negedge clk);
            chk("single_val", 128'(bus.l15_val), 128'(1));
            chk("single_payload", bus.l15_payload, 128'hABCD);
            chk("single_portid", 128'(bus.l15_portid), 128'(2));
            chk("single_cnt", cnt_of(2), 128'(1));
            next();
        end
        bus.l15_header_ack = 1'b0;
        @(negedge clk);
        chk("single_idle", 128'(bus.l15_val), 128'(0));
        bus.rtrn_valid  = 1'b1;
        bus.rtrn_portid = 3'd2;
        next();
        bus.rtrn_valid = 1'b0;
        @(negedge clk);
        chk("single_rtrn", cnt_of(2), 128'(0));

        // reset in the middle of an issue
        next();
        bus.req_valid = 5'b00100;
        expect_req(2, 128'hABCD);
        next();
        bus.req_valid = '0;
        @(negedge clk);
        chk("midrst_before", 128'(bus.l15_val), 128'(1));
        #1 rst = 1'b1;
        #1;
        chk("midrst_val", 128'(bus.l15_val), 128'(0));
        chk("midrst_cnt", 128'(bus.outst_cnt), 128'(0));
        chk("midrst_err", 128'(bus.err), 128'(0));
        next();
        next();
        rst = 1'b0;

        // fairness: all ports valid, L1.5 acks every cycle
        for (int i = 0; i < NUM_PORTS; i++) set_pl(i, pl(i, 0));
        for (int k = 0; k < 10; k++) expect_req(k % 5, pl(k % 5, 0));
        bus.req_valid = '1;
        bus.l15_header_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rr_ready", 128'(bus.req_ready), 128'(1) << (k % 5));
            if (k > 0) chk("rr_nobubble", 128'(bus.l15_val), 128'(1));
            next();
        end
        bus.req_valid = '0;
        @(negedge clk);
        chk("rr_last_val", 128'(bus.l15_val), 128'(1));
        next();
        bus.l15_header_ack = 1'b0;
        @(negedge clk);
        chk("rr_idle", 128'(bus.l15_val), 128'(0));
        chk("rr_cnts", 128'(bus.outst_cnt), 128'({5{3'd2}}));

        // credit limit on port 1
        do_reset();
        set_pl(1, pl(1, 7));
        bus.req_valid = 5'b00010;
        bus.l15_header_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_req(1, pl(1, 7));
            @(negedge clk);
            chk("credit_ready", 128'(bus.req_ready), 128'(5'b00010));
            next();
        end
        @(negedge clk);
        chk("credit_block", 128'(bus.req_ready), 128'(0));
        chk("credit_full", cnt_of(1), 128'(4));
        next();
        bus.rtrn_valid  = 1'b1;
        bus.rtrn_portid = 3'd1;
        @(negedge clk);
        chk("credit_rtrn_cycle", 128'(bus.req_ready), 128'(0));
        next();
        bus.rtrn_valid = 1'b0;
        expect_req(1, pl(1, 7));
        @(negedge clk);
        chk("credit_back", 128'(bus.req_ready), 128'(5'b00010));
        next();
        bus.req_valid = '0;
        next();
        bus.l15_header_ack = 1'b0;
        @(negedge clk);
        chk("credit_cnt_end", cnt_of(1), 128'(4));

        // saturated port 0 is skipped, pointer wraps back to it once a credit returns
        do_reset();
        set_pl(0, pl(0, 9));
        set_pl(3, pl(3, 9));
        bus.req_valid = 5'b00001;
        bus.l15_header_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_req(0, pl(0, 9));
            @(negedge clk);
            chk("skip_fill", 128'(bus.req_ready), 128'(5'b00001));
            next();
        end
        bus.req_valid = 5'b01001;
        expect_req(3, pl(3, 9));
        @(negedge clk);
        chk("skip_only3", 128'(bus.req_ready), 128'(5'b01000));
        next();
        bus.rtrn_valid  = 1'b1;
        bus.rtrn_portid = 3'd0;
        expect_req(3, pl(3, 9));
        @(negedge clk);
        chk("skip_only3b", 128'(bus.req_ready), 128'(5'b01000));
        next();
        bus.rtrn_valid = 1'b0;
        expect_req(0, pl(0, 9));
        @(negedge clk);
        chk("skip_wrap", 128'(bus.req_ready), 128'(5'b00001));
        next();
        bus.req_valid = '0;
        next();
        bus.l15_header_ack = 1'b0;
        @(negedge clk);
        chk("skip_cnt0", cnt_of(0), 128'(4));
        chk("skip_cnt3", cnt_of(3), 128'(2));

        // same-cycle grant and return on port 4, then error cases
        do_reset();
        set_pl(4, pl(4, 5));
        bus.req_valid = 5'b10000;
        bus.l15_header_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            expect_req(4, pl(4, 5));
            if (k == 2) begin
                bus.rtrn_valid  = 1'b1;
                bus.rtrn_portid = 3'd4;
            end
            @(negedge clk);
            chk("incdec_ready", 128'(bus.req_ready), 128'(5'b10000));
            next();
        end
        bus.rtrn_valid = 1'b0;
        bus.req_valid  = '0;
        @(negedge clk);
        chk("incdec_hold", cnt_of(4), 128'(2));
        chk("err_clear", 128'(bus.err), 128'(0));
        next();
        bus.l15_header_ack = 1'b0;
        bus.rtrn_valid  = 1'b1;
        bus.rtrn_portid = 3'd0;
        next();
        bus.rtrn_valid = 1'b0;
        @(negedge clk);
        chk("err_underflow", 128'(bus.err), 128'(1));
        chk("err_cnt0", cnt_of(0), 128'(0));
        repeat (3) next();
        @(negedge clk);
        chk("err_sticky", 128'(bus.err), 128'(1));
        chk("err_cnt4", cnt_of(4), 128'(2));
        do_reset();
        @(negedge clk);
        chk("err_rst", 128'(bus.err), 128'(0));
        next();
        bus.rtrn_valid  = 1'b1;
        bus.rtrn_portid = 3'd6;
        next();
        bus.rtrn_valid = 1'b0;
        @(negedge clk);
        chk("err_badid", 128'(bus.err), 128'(1));
        chk("err_badid_cnt", 128'(bus.outst_cnt), 128'(0));

        chk("sb_drain", 128'(sbq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
